// File: rtl/des_ip_loader_pkg.sv
// Shared DES definitions: byte-loader FSM encoding and the initial-permutation table.
package des_ip_loader_pkg;

  typedef enum logic {
    COLLECT = 1'b0,
    LAST    = 1'b1
  } loader_state_e;

  // Output DES bit i (1-based) takes assembled DES bit IP_TABLE[i-1]; DES bit 1 is the MSB.
  localparam int IP_TABLE [64] = '{
    58, 50, 42, 34, 26, 18, 10, 2,
    60, 52, 44, 36, 28, 20, 12, 4,
    62, 54, 46, 38, 30, 22, 14, 6,
    64, 56, 48, 40, 32, 24, 16, 8,
    57, 49, 41, 33, 25, 17,  9, 1,
    59, 51, 43, 35, 27, 19, 11, 3,
    61, 53, 45, 37, 29, 21, 13, 5,
    63, 55, 47, 39, 31, 23, 15, 7
  };

endpackage

// File: rtl/des_initial_permutation.sv
// DES initial permutation: pure wiring, DES bit j lives at vector index 64-j.
module des_initial_permutation
  import des_ip_loader_pkg::*;
(
  input  logic [63:0] blk_in,
  output logic [63:0] blk_out
);

  for (genvar i = 0; i < 64; i++) begin : g_bit
    localparam int SRC = 64 - IP_TABLE[i];
    assign blk_out[63-i] = blk_in[SRC];
  end

endmodule

// File: rtl/des_ip_loader.sv
// Assembles 8 plaintext bytes into a DES block and registers IP(block) behind a
// valid/ready handshake; bytes 1-7 of the next block are collected while the output is held.
module des_ip_loader
  import des_ip_loader_pkg::*;
#(
  parameter int BYTES_PER_BLOCK = 8
) (
  input  logic        wClk,
  input  logic        wResetN,
  input  logic [8:1]  wByteIn,
  input  logic        wByteValid,
  output logic        rByteReady,
  input  logic        wFlush,
  output logic [64:1] rBlockOut,
  output logic        rBlockValid,
  input  logic        wBlockReady,
  output logic [2:0]  rByteCount
);

  localparam logic [2:0] LAST_IDX = 3'(BYTES_PER_BLOCK - 1);

  loader_state_e state;
  logic [55:0]   asm_buf;
  logic [63:0]   blk_in;
  logic [63:0]   blk_ip;
  logic          accept;
  logic          load;

  assign rByteReady = !((rByteCount == LAST_IDX) && rBlockValid && !wBlockReady);
  assign accept     = wByteValid && rByteReady;
  assign load       = accept && !wFlush && (state == LAST);

  // The 8th byte bypasses the buffer so the block loads on its own accept edge.
  assign blk_in = {asm_buf, wByteIn};

  des_initial_permutation u_ip (
    .blk_in  (blk_in),
    .blk_out (blk_ip)
  );

  always_ff @(posedge wClk or negedge wResetN) begin
    if (!wResetN) begin
      state       <= COLLECT;
      rByteCount  <= '0;
      asm_buf     <= '0;
      rBlockOut   <= '0;
      rBlockValid <= 1'b0;
    end else begin
      if (wFlush) begin
        state      <= COLLECT;
        rByteCount <= '0;
        asm_buf    <= '0;
      end else if (accept) begin
        case (state)
          COLLECT: begin
            asm_buf[6'd48 - {rByteCount, 3'b000} +: 8] <= wByteIn;
            rByteCount <= rByteCount + 3'd1;
            if (rByteCount == LAST_IDX - 3'd1) state <= LAST;
          end
          LAST: begin
            asm_buf    <= '0;
            rByteCount <= '0;
            state      <= COLLECT;
          end
          default: state <= COLLECT;
        endcase
      end

      if (load) begin
        rBlockOut   <= blk_ip;
        rBlockValid <= 1'b1;
      end else if (rBlockValid && wBlockReady) begin
        rBlockValid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_des_ip_loader.sv
// Directed DES vectors plus randomized traffic against a queue-based reference model.
module tb_des_ip_loader;

  logic        wClk = 1'b0;
  logic        wResetN;
  logic [8:1]  wByteIn;
  logic        wByteValid;
  logic        rByteReady;
  logic        wFlush;
  logic [64:1] rBlockOut;
  logic        rBlockValid;
  logic        wBlockReady;
  logic [2:0]  rByteCount;

  des_ip_loader #(.BYTES_PER_BLOCK(8)) dut (
    .wClk        (wClk),
    .wResetN     (wResetN),
    .wByteIn     (wByteIn),
    .wByteValid  (wByteValid),
    .rByteReady  (rByteReady),
    .wFlush      (wFlush),
    .rBlockOut   (rBlockOut),
    .rBlockValid (rBlockValid),
    .wBlockReady (wBlockReady),
    .rByteCount  (rByteCount)
  );

  always #5 wClk = ~wClk;

  int n_checks = 0;
  int n_pass   = 0;
  bit chk_en   = 1'b0;

  int IPT [64] = '{
    58, 50, 42, 34, 26, 18, 10, 2,
    60, 52, 44, 36, 28, 20, 12, 4,
    62, 54, 46, 38, 30, 22, 14, 6,
    64, 56, 48, 40, 32, 24, 16, 8,
    57, 49, 41, 33, 25, 17,  9, 1,
    59, 51, 43, 35, 27, 19, 11, 3,
    61, 53, 45, 37, 29, 21, 13, 5,
    63, 55, 47, 39, 31, 23, 15, 7
  };

  // Reference model state
  logic [7:0]  m_q[$];
  logic        m_vld = 1'b0;
  logic [63:0] m_out = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [63:0] des_bit_get(input logic [63:0] x, input int j);
    return {63'd0, x[64-j]};
  endfunction

  function automatic logic [63:0] ip_model(input logic [63:0] x);
    logic [63:0] r = '0;
    for (int i = 1; i <= 64; i++) r = (r << 1) | des_bit_get(x, IPT[i-1]);
    return r;
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_vld = 1'b0;
    m_out = '0;
  endtask

  // Called at each rising edge with the inputs that were applied during the cycle.
  task automatic model_step();
    logic rdy, acc, newload;
    logic [63:0] blk;
    rdy = !(m_q.size() == 7 && m_vld && !wBlockReady);
    acc = wByteValid && rdy;
    newload = 1'b0;
    if (wFlush) m_q.delete();
    else if (acc) begin
      m_q.push_back(wByteIn);
      if (m_q.size() == 8) begin
        blk = '0;
        foreach (m_q[k]) blk = {blk[55:0], m_q[k]};
        m_out = ip_model(blk);
        newload = 1'b1;
        m_q.delete();
      end
    end
    if (newload) m_vld = 1'b1;
    else if (m_vld && wBlockReady) m_vld = 1'b0;
  endtask

  always @(negedge wClk) begin
    if (chk_en && wResetN) begin
      check("ready", {63'd0, rByteReady}, {63'd0, !(m_q.size() == 7 && m_vld && !wBlockReady)});
      check("count", {61'd0, rByteCount}, 64'(m_q.size()));
      check("valid", {63'd0, rBlockValid}, {63'd0, m_vld});
      check("block", rBlockOut, m_out);
    end
  end

  task automatic cyc(input logic [7:0] b, input logic v, input logic fl, input logic br);
    wByteIn     = b;
    wByteValid  = v;
    wFlush      = fl;
    wBlockReady = br;
    @(posedge wClk);
    model_step();
    #1;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_out"},   rBlockOut, 64'h0);
    check({tag, "_valid"}, {63'd0, rBlockValid}, 64'd0);
    check({tag, "_count"}, {61'd0, rByteCount}, 64'd0);
    check({tag, "_ready"}, {63'd0, rByteReady}, 64'd1);
  endtask

  logic [7:0] fips [8] = '{8'h01, 8'h23, 8'h45, 8'h67, 8'h89, 8'hAB, 8'hCD, 8'hEF};
  logic [7:0] onebit [8] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h40};

  initial begin
    wResetN = 1'b0; wByteIn = '0; wByteValid = 1'b0; wFlush = 1'b0; wBlockReady = 1'b0;
    model_reset();
    repeat (2) @(posedge wClk);
    #1;
    check_reset_vals("rst0");
    wResetN = 1'b1;
    chk_en  = 1'b1;

    // FIPS vector
    for (int k = 0; k < 8; k++) cyc(fips[k], 1'b1, 1'b0, 1'b1);
    check("fips_out", rBlockOut, 64'hCC00CCFFF0AAF0AA);
    check("fips_valid", {63'd0, rBlockValid}, 64'd1);

    // Single-bit vector
    for (int k = 0; k < 8; k++) cyc(onebit[k], 1'b1, 1'b0, 1'b1);
    check("bit_out", rBlockOut, 64'h8000000000000000);
    check("bit_valid", {63'd0, rBlockValid}, 64'd1);
    cyc(8'h00, 1'b0, 1'b0, 1'b1);

    // Backpressure: 15 bytes with consumer stalled, then the 16th
    for (int k = 0; k < 15; k++)
      cyc((k < 8) ? fips[k] : onebit[k-8], 1'b1, 1'b0, 1'b0);
    cyc(8'h40, 1'b1, 1'b0, 1'b0);
    cyc(8'h40, 1'b1, 1'b0, 1'b0);
    check("bp_ready", {63'd0, rByteReady}, 64'd0);
    check("bp_count", {61'd0, rByteCount}, 64'd7);
    check("bp_hold", rBlockOut, 64'hCC00CCFFF0AAF0AA);
    cyc(8'h40, 1'b1, 1'b0, 1'b1);
    check("swap_out", rBlockOut, 64'h8000000000000000);
    check("swap_valid", {63'd0, rBlockValid}, 64'd1);
    cyc(8'h00, 1'b0, 1'b0, 1'b1);

    // Flush drops partial block and the simultaneous byte
    cyc(8'h11, 1'b1, 1'b0, 1'b1);
    cyc(8'h22, 1'b1, 1'b0, 1'b1);
    cyc(8'h33, 1'b1, 1'b0, 1'b1);
    cyc(8'h55, 1'b1, 1'b1, 1'b1);
    check("flush_count", {61'd0, rByteCount}, 64'd0);
    for (int k = 0; k < 8; k++) cyc(8'hFF, 1'b1, 1'b0, 1'b1);
    check("flush_out", rBlockOut, 64'hFFFFFFFFFFFFFFFF);
    check("flush_valid", {63'd0, rBlockValid}, 64'd1);
    cyc(8'h00, 1'b0, 1'b0, 1'b1);

    // Reset with a block held and 5 bytes buffered
    for (int k = 0; k < 13; k++) cyc(8'(k * 37 + 5), 1'b1, 1'b0, 1'b0);
    check("pre_rst_count", {61'd0, rByteCount}, 64'd5);
    wResetN = 1'b0;
    #1;
    check_reset_vals("rst1");
    model_reset();
    #1;
    wResetN = 1'b1;
    for (int k = 0; k < 8; k++) cyc(fips[k], 1'b1, 1'b0, 1'b1);
    check("fresh_out", rBlockOut, 64'hCC00CCFFF0AAF0AA);
    check("fresh_valid", {63'd0, rBlockValid}, 64'd1);

    // Randomized traffic
    for (int n = 0; n < 3000; n++)
      cyc(8'($urandom), ($urandom_range(3) != 0), ($urandom_range(19) == 0),
          1'($urandom_range(1)));

    cyc(8'h00, 1'b0, 1'b0, 1'b1);
    cyc(8'h00, 1'b0, 1'b0, 1'b1);
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/des_ip_loader.md
DES_IP_LOADER -- requirements
Module: des_ip_loader

Interface
REQ-001 SHALL have parameter BYTES_PER_BLOCK, default 8, number of input bytes per 64-bit DES block; only value 8 is supported.
REQ-002 SHALL have port wClk  input  1  single clock; all state changes on its rising edge.
REQ-003 SHALL have port wResetN  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port wByteIn  input  8 [8:1]  plaintext byte; bit 8 is the byte MSB.
REQ-005 SHALL have port wByteValid  input  1  wByteIn is valid this cycle.
REQ-006 SHALL have port rByteReady  output  1  block accepts a byte this cycle.
REQ-007 SHALL have port wFlush  input  1  synchronous abort of a partially assembled block.
REQ-008 SHALL have port rBlockOut  output  64 [64:1]  block after initial permutation (IP); bit 1 is the DES MSB.
REQ-009 SHALL have port rBlockValid  output  1  rBlockOut holds an unconsumed block.
REQ-010 SHALL have port wBlockReady  input  1  downstream consumes rBlockOut this cycle.
REQ-011 SHALL have port rByteCount  output  3  number of bytes currently held in the assembly buffer (0-7).

Function
REQ-012 SHALL accept a byte on a rising edge when wByteValid and rByteReady are both 1.
REQ-013 SHALL place the k-th accepted byte (k=0..7) into assembly bits [8k+1 : 8k+8], so the first byte forms DES bits 1-8.
REQ-014 SHALL, on accepting the 8th byte, load rBlockOut with IP(assembled block) in the same edge and set rBlockValid=1; latency from the 8th byte handshake to rBlockValid is 1 cycle.
REQ-015 SHALL compute IP as output bit i = assembled bit IP[i], IP = 58 50 42 34 26 18 10 2 / 60 52 44 36 28 20 12 4 / 62 54 46 38 30 22 14 6 / 64 56 48 40 32 24 16 8 / 57 49 41 33 25 17 9 1 / 59 51 43 35 27 19 11 3 / 61 53 45 37 29 21 13 5 / 63 55 47 39 31 23 15 7.
REQ-016 SHALL clear rBlockValid when rBlockValid and wBlockReady are both 1, unless a new block loads on the same edge, in which case rBlockValid stays 1 with the new data.
REQ-017 SHALL hold rBlockOut stable while rBlockValid=1 and wBlockReady=0.
REQ-018 SHALL keep assembling bytes 1-7 of the next block while rBlockOut is still held (double buffering).
REQ-019 SHALL drive rByteReady = NOT (rByteCount==7 AND rBlockValid AND NOT wBlockReady); this is combinational from state and wBlockReady.
REQ-020 SHALL implement FSM states COLLECT (count<7) and LAST (count==7); COLLECT->LAST on the 7th byte accept; LAST->COLLECT on the 8th byte accept or on flush.
REQ-021 SHALL, on wFlush=1, reset rByteCount to 0 and discard the partial block; this has priority over a simultaneous byte accept, and the byte is dropped.
REQ-022 SHALL NOT let wFlush affect rBlockOut or rBlockValid.
REQ-023 SHALL wrap rByteCount from 7 to 0 on the 8th byte accept.

Reset
REQ-024 SHALL, while wResetN=0, force rBlockOut=64'h0, rBlockValid=0, rByteCount=0, FSM=COLLECT, assembly buffer=0, and rByteReady=1.
REQ-025 SHALL discard a partially assembled block or an unconsumed output block if reset asserts mid-operation; the first byte after reset deasserts is byte 0.

Structure
REQ-026 SHALL take the IP table constant and the FSM state encoding from the shared DES package used by the round and final-permutation logic.
REQ-027 SHALL isolate the IP in one combinational sub-module, des_initial_permutation (64-bit in, 64-bit out); the remaining logic is sequential.

Verification
REQ-028 SHALL cover this FIPS vector: bytes 01 23 45 67 89 AB CD EF with wBlockReady=1 -> rBlockOut=64'hCC00CCFFF0AAF0AA, rBlockValid=1 one cycle after the 8th byte.
REQ-029 SHALL cover a single-bit check: bytes 00 00 00 00 00 00 00 40 -> rBlockOut=64'h8000000000000000.
REQ-030 SHALL cover backpressure: wBlockReady=0 and 15 bytes offered back-to-back -> rByteReady=0 at rByteCount=7; rBlockOut unchanged; after wBlockReady=1 for one cycle, the 16th byte is accepted and the second block loads.
REQ-031 SHALL cover flush: 3 bytes, then wFlush=1 together with wByteValid=1 -> rByteCount=0, byte dropped; the next 8 bytes FF x8 -> rBlockOut=64'hFFFFFFFFFFFFFFFF.
REQ-032 SHALL cover mid-operation reset: wResetN pulsed low after 5 bytes and with a block held -> all outputs at reset values immediately (async); the next 8 bytes form a fresh block.
REQ-033 SHALL cover simultaneous events: consume and new-block load on the same edge -> rBlockValid stays 1, rBlockOut equals the new block, and no block is lost or duplicated.
